// File: rtl/mac_array_q_if.sv
// Operand-in / result-out stream bundle for mac_array_q.
// master = operand source + result consumer, slave = the MAC array.
interface mac_array_q_if #(
  parameter int LANES = 28,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int M_W   = 16,
  parameter int OUT_W = 8,
  parameter int K_W   = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*IN_W-1:0]  in_a;
  logic [LANES*IN_W-1:0]  in_b;
  logic [K_W-1:0]         k_len;
  logic [M_W-1:0]         qm;
  logic [5:0]             qshift;
  logic [OUT_W-1:0]       qzp;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*ACC_W-1:0] out_acc;
  logic [LANES*OUT_W-1:0] out_q;

  modport master (
    output in_valid, in_a, in_b, k_len, qm, qshift, qzp, out_ready,
    input  in_ready, out_valid, out_acc, out_q
  );
  modport slave (
    input  in_valid, in_a, in_b, k_len, qm, qshift, qzp, out_ready,
    output in_ready, out_valid, out_acc, out_q
  );
endinterface

// File: rtl/mac_array_q.sv
// Parametrised signed MAC array with a K-beat dot product per lane and a
// 2-stage requantise (scale, rounding shift, zero point, saturate) pipeline.
module mac_lane #(
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int M_W   = 16,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic                    accum,
  input  logic                    sc1,
  input  logic                    sc2,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  input  logic signed [M_W-1:0]   qm,
  input  logic [5:0]              qs,
  input  logic signed [OUT_W-1:0] qzp,
  output logic [ACC_W-1:0]        out_acc,
  output logic [OUT_W-1:0]        out_q,
  output logic                    ovf
);
  localparam int P_W = ACC_W + M_W;
  localparam logic signed [P_W+1:0] QMAX = (P_W+2)'((1 <<< (OUT_W-1)) - 1);
  localparam logic signed [P_W+1:0] QMIN = -QMAX - 1;

  logic signed [ACC_W-1:0] acc_q, acc_d, prod, sum;
  logic signed [P_W-1:0]   p_q, p_d;
  logic [ACC_W-1:0]        oacc_q, oacc_d;
  logic [OUT_W-1:0]        oq_q, oq_d, sat;
  logic [5:0]              s_eff;
  logic signed [P_W:0]     rnd, rsum, r;
  logic signed [P_W+1:0]   v;

  always_comb begin
    prod  = ACC_W'(a) * ACC_W'(b);
    sum   = acc_q + prod;
    // raw signed-add overflow; the controller decides whether it counts
    ovf   = (acc_q[ACC_W-1] == prod[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    acc_d = acc_q;
    if (clr)        acc_d = '0;
    else if (load)  acc_d = prod;
    else if (accum) acc_d = sum;
    p_d   = sc1 ? P_W'(acc_q) * P_W'(qm) : p_q;
    s_eff = (int'(qs) > P_W-1) ? 6'(P_W-1) : qs;
    rnd   = (s_eff == 6'd0) ? '0 : ((P_W+1)'(1) <<< (s_eff - 6'd1));
    rsum  = (P_W+1)'(p_q) + rnd;
    r     = rsum >>> s_eff;
    v     = (P_W+2)'(r) + (P_W+2)'(qzp);
    if (v > QMAX)      sat = OUT_W'(QMAX);
    else if (v < QMIN) sat = OUT_W'(QMIN);
    else               sat = OUT_W'(v);
    oq_d   = sc2 ? sat : oq_q;
    oacc_d = sc2 ? acc_q : oacc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      p_q    <= '0;
      oacc_q <= '0;
      oq_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      p_q    <= p_d;
      oacc_q <= oacc_d;
      oq_q   <= oq_d;
    end
  end

  assign out_acc = oacc_q;
  assign out_q   = oq_q;
endmodule

module mac_array_q #(
  parameter int LANES = 28,
  parameter int IN_W  = 8,
  parameter int ACC_W = 32,
  parameter int M_W   = 16,
  parameter int OUT_W = 8,
  parameter int K_W   = 16
) (
  input  logic          clk,
  input  logic          main_rst,
  input  logic          acc_clr,
  mac_array_q_if.slave  bus,
  output logic          acc_ovf,
  output logic          busy
);
  typedef enum logic [2:0] {IDLE, ACC, SC1, SC2, OUT} state_e;

  state_e           state_q, state_d;
  logic [K_W-1:0]   cnt_q, cnt_d, klen_q, klen_d, keff, cnt_inc;
  logic [M_W-1:0]   qm_q, qm_d;
  logic [5:0]       qs_q, qs_d;
  logic [OUT_W-1:0] qzp_q, qzp_d;
  logic             ovf_q, ovf_d;
  logic             fire_in, load, accum, sc1, sc2, clr;
  logic [LANES-1:0] lane_ovf;
  logic [LANES-1:0][ACC_W-1:0] acc_o;
  logic [LANES-1:0][OUT_W-1:0] q_o;

  assign bus.in_ready  = (state_q == IDLE) || (state_q == ACC);
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_acc   = acc_o;
  assign bus.out_q     = q_o;
  assign fire_in       = bus.in_valid && bus.in_ready;
  assign acc_ovf       = ovf_q;
  assign busy          = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    qm_d    = qm_q;
    qs_d    = qs_q;
    qzp_d   = qzp_q;
    ovf_d   = ovf_q;
    load    = 1'b0;
    accum   = 1'b0;
    sc1     = 1'b0;
    sc2     = 1'b0;
    clr     = 1'b0;
    keff    = (bus.k_len == '0) ? K_W'(1) : bus.k_len;
    cnt_inc = cnt_q + K_W'(1);
    // abort wins over any beat or output handshake in the same cycle
    if (acc_clr) begin
      state_d = IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      clr     = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (fire_in) begin
          klen_d  = keff;
          qm_d    = bus.qm;
          qs_d    = bus.qshift;
          qzp_d   = bus.qzp;
          cnt_d   = K_W'(1);
          ovf_d   = 1'b0;
          load    = 1'b1;
          state_d = (keff == K_W'(1)) ? SC1 : ACC;
        end
        ACC: if (fire_in) begin
          accum = 1'b1;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | (|lane_ovf);
          if (cnt_inc == klen_q) state_d = SC1;
        end
        SC1: begin
          sc1     = 1'b1;
          state_d = SC2;
        end
        SC2: begin
          sc2     = 1'b1;
          state_d = OUT;
        end
        OUT: if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge main_rst) begin
    if (!main_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      qm_q    <= '0;
      qs_q    <= '0;
      qzp_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      qm_q    <= qm_d;
      qs_q    <= qs_d;
      qzp_q   <= qzp_d;
      ovf_q   <= ovf_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(.IN_W(IN_W), .ACC_W(ACC_W), .M_W(M_W), .OUT_W(OUT_W)) u_lane (
      .clk     (clk),
      .rst_n   (main_rst),
      .clr     (clr),
      .load    (load),
      .accum   (accum),
      .sc1     (sc1),
      .sc2     (sc2),
      .a       (bus.in_a[i*IN_W +: IN_W]),
      .b       (bus.in_b[i*IN_W +: IN_W]),
      .qm      (qm_q),
      .qs      (qs_q),
      .qzp     (qzp_q),
      .out_acc (acc_o[i]),
      .out_q   (q_o[i]),
      .ovf     (lane_ovf[i])
    );
  end
endmodule

// File: tb/tb_mac_array_q.sv
// Randomised + directed bench for mac_array_q against an arithmetic reference.
module tb_mac_array_q;
  localparam int L = 28, IW = 8, AW = 32, MW = 16, OW = 8, KW = 16;
  localparam int L2 = 2, AW2 = 16;
  typedef logic [1023:0] wv_t;

  logic clk = 1'b0, main_rst = 1'b0, acc_clr = 1'b0, clr2 = 1'b0;
  logic acc_ovf, busy, acc_ovf2, busy2;
  int   checks = 0, errors = 0;
  bit   use_fix = 1'b1, gaps = 1'b0;
  int   fa = 0, fb = 0;
  logic [L*AW-1:0] exp_acc;
  logic [L*OW-1:0] exp_q;

  always #5 clk = ~clk;

  mac_array_q_if #(.LANES(L), .IN_W(IW), .ACC_W(AW), .M_W(MW), .OUT_W(OW), .K_W(KW)) bus ();
  mac_array_q_if #(.LANES(L2), .IN_W(IW), .ACC_W(AW2), .M_W(MW), .OUT_W(OW), .K_W(KW)) bus2 ();

  mac_array_q #(.LANES(L), .IN_W(IW), .ACC_W(AW), .M_W(MW), .OUT_W(OW), .K_W(KW)) dut (
    .clk(clk), .main_rst(main_rst), .acc_clr(acc_clr), .bus(bus), .acc_ovf(acc_ovf), .busy(busy));
  mac_array_q #(.LANES(L2), .IN_W(IW), .ACC_W(AW2), .M_W(MW), .OUT_W(OW), .K_W(KW)) dut2 (
    .clk(clk), .main_rst(main_rst), .acc_clr(clr2), .bus(bus2), .acc_ovf(acc_ovf2), .busy(busy2));

  task automatic chk(input string tag, input wv_t obs, input wv_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint wrapv(input longint x, input int w);
    longint m, y;
    m = longint'(1) <<< w;
    y = x & (m - 1);
    if (y >= m / 2) y = y - m;
    return y;
  endfunction

  // scale, round half up, add zero point, saturate -- plain 64-bit arithmetic
  function automatic longint quant(input longint acc, input longint qmv, input int s,
                                   input longint z, input int aw, input int mw, input int ow);
    longint p, half, r, v, hi, lo;
    int se;
    p    = acc * qmv;
    se   = (s > aw + mw - 1) ? aw + mw - 1 : s;
    half = (se > 0) ? (longint'(1) <<< (se - 1)) : 0;
    r    = (p + half) >>> se;
    v    = r + z;
    hi   = (longint'(1) <<< (ow - 1)) - 1;
    lo   = -hi - 1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction

  task automatic run_job(input int k, input int qmv, input int sv, input int zv, input int hold);
    longint acc [L];
    longint ns, lim;
    bit     ovf;
    int     keff, lat, a, b;
    logic [L*IW-1:0] va, vb;
    keff = (k == 0) ? 1 : k;
    ovf  = 1'b0;
    lim  = longint'(1) <<< (AW - 1);
    foreach (acc[i]) acc[i] = 0;
    bus.k_len = KW'(k); bus.qm = MW'(qmv); bus.qshift = 6'(sv); bus.qzp = OW'(zv);
    for (int bt = 0; bt < keff; bt++) begin
      if (gaps && bt > 0) begin
        bus.in_valid = 1'b0;
        for (int i = 0; i < L; i++) begin
          bus.in_a[i*IW +: IW] = IW'($urandom); bus.in_b[i*IW +: IW] = IW'($urandom);
        end
        @(negedge clk);
      end
      for (int i = 0; i < L; i++) begin
        a = use_fix ? fa : int'($urandom_range(0, 255)) - 128;
        b = use_fix ? fb : int'($urandom_range(0, 255)) - 128;
        va[i*IW +: IW] = IW'(a); vb[i*IW +: IW] = IW'(b);
        ns = acc[i] + longint'(a) * longint'(b);
        if (ns >= lim || ns < -lim) ovf = 1'b1;
        acc[i] = wrapv(ns, AW);
      end
      bus.in_a = va; bus.in_b = vb; bus.in_valid = 1'b1;
      chk("in_ready_beat", wv_t'(bus.in_ready), wv_t'(1'b1));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("latency", wv_t'(lat), wv_t'(3));
    for (int i = 0; i < L; i++) begin
      exp_acc[i*AW +: AW] = AW'(acc[i]);
      exp_q[i*OW +: OW]   = OW'(quant(acc[i], longint'(qmv), sv, longint'(zv), AW, MW, OW));
    end
    chk("out_acc", wv_t'(bus.out_acc), wv_t'(exp_acc));
    chk("out_q", wv_t'(bus.out_q), wv_t'(exp_q));
    chk("acc_ovf", wv_t'(acc_ovf), wv_t'(ovf));
    chk("in_ready_out", wv_t'(bus.in_ready), wv_t'(1'b0));
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk("hold_valid", wv_t'(bus.out_valid), wv_t'(1'b1));
      chk("hold_acc", wv_t'(bus.out_acc), wv_t'(exp_acc));
      chk("hold_q", wv_t'(bus.out_q), wv_t'(exp_q));
      chk("hold_ready", wv_t'(bus.in_ready), wv_t'(1'b0));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_valid", wv_t'(bus.out_valid), wv_t'(1'b0));
    chk("post_busy", wv_t'(busy), wv_t'(1'b0));
  endtask

  task automatic beat(input int a, input int b, input bit clr);
    for (int i = 0; i < L; i++) begin
      bus.in_a[i*IW +: IW] = IW'(a); bus.in_b[i*IW +: IW] = IW'(b);
    end
    bus.in_valid = 1'b1; acc_clr = clr;
    @(negedge clk);
    bus.in_valid = 1'b0; acc_clr = 1'b0;
  endtask

  initial begin
    bit seen;
    int lat;
    logic [L2*AW2-1:0] e2acc;
    logic [L2*OW-1:0]  e2q;
    bus.in_valid = 0; bus.in_a = '0; bus.in_b = '0; bus.k_len = '0; bus.qm = '0;
    bus.qshift = '0; bus.qzp = '0; bus.out_ready = 0;
    bus2.in_valid = 0; bus2.in_a = '0; bus2.in_b = '0; bus2.k_len = '0; bus2.qm = '0;
    bus2.qshift = '0; bus2.qzp = '0; bus2.out_ready = 0;
    #12;
    chk("rst_out_valid", wv_t'(bus.out_valid), wv_t'(1'b0));
    chk("rst_in_ready", wv_t'(bus.in_ready), wv_t'(1'b1));
    chk("rst_busy", wv_t'(busy), wv_t'(1'b0));
    chk("rst_ovf", wv_t'(acc_ovf), wv_t'(1'b0));
    chk("rst_acc", wv_t'(bus.out_acc), wv_t'(0));
    chk("rst_q", wv_t'(bus.out_q), wv_t'(0));
    @(negedge clk); main_rst = 1'b1; @(negedge clk);

    fa = 2;    fb = 3;   run_job(3, 8, 8, 0, 0);
    fa = 127;  fb = 127; run_job(4, 256, 0, 0, 2);
    fa = -128; fb = 127; run_job(1, 1, 0, 0, 0);
    fa = -3;   fb = 1;   run_job(1, 1, 1, 5, 0);
    run_job(0, 1, 1, 5, 1);
    fa = 9; fb = -4; gaps = 1'b1; run_job(3, 3, 2, -7, 10);
    gaps = 1'b0;

    use_fix = 1'b0;
    repeat (12) begin
      gaps = 1'($urandom_range(0, 1));
      run_job(int'($urandom_range(0, 6)), int'($urandom_range(0, 65535)) - 32768,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 63)) : int'($urandom_range(0, 20)),
              int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)));
    end
    gaps = 1'b0; use_fix = 1'b1;

    // abort with acc_clr colliding with a third beat
    bus.k_len = KW'(4);
    beat(5, 7, 0); beat(5, 7, 0); beat(5, 7, 1);
    chk("clr_busy", wv_t'(busy), wv_t'(1'b0));
    chk("clr_in_ready", wv_t'(bus.in_ready), wv_t'(1'b1));
    chk("clr_ovf", wv_t'(acc_ovf), wv_t'(1'b0));
    chk("clr_keep_acc", wv_t'(bus.out_acc), wv_t'(exp_acc));
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= bus.out_valid; end
    chk("clr_no_valid", wv_t'(seen), wv_t'(1'b0));

    // asynchronous reset mid-accumulation
    beat(5, 7, 0); beat(5, 7, 0);
    #2 main_rst = 1'b0;
    #1;
    chk("arst_busy", wv_t'(busy), wv_t'(1'b0));
    chk("arst_valid", wv_t'(bus.out_valid), wv_t'(1'b0));
    chk("arst_acc", wv_t'(bus.out_acc), wv_t'(0));
    @(negedge clk); main_rst = 1'b1; @(negedge clk);
    fa = 1; fb = 1; run_job(2, 1, 0, 0, 0);

    // narrow-accumulator instance: wrap and sticky overflow
    bus2.k_len = KW'(3); bus2.qm = MW'(1); bus2.qshift = 6'd0; bus2.qzp = '0;
    bus2.in_a = {L2{8'sd127}}; bus2.in_b = {L2{8'sd127}}; bus2.in_valid = 1'b1;
    repeat (3) @(negedge clk);
    bus2.in_valid = 1'b0;
    lat = 1;
    while (!bus2.out_valid && lat < 10) begin @(negedge clk); lat++; end
    chk("w_latency", wv_t'(lat), wv_t'(3));
    for (int i = 0; i < L2; i++) begin
      e2acc[i*AW2 +: AW2] = AW2'(wrapv(3 * 127 * 127, AW2));
      e2q[i*OW +: OW]     = OW'(quant(wrapv(3 * 127 * 127, AW2), 1, 0, 0, AW2, MW, OW));
    end
    chk("w_acc", wv_t'(bus2.out_acc), wv_t'(e2acc));
    chk("w_q", wv_t'(bus2.out_q), wv_t'(e2q));
    chk("w_ovf", wv_t'(acc_ovf2), wv_t'(1'b1));
    bus2.out_ready = 1'b1; @(negedge clk); bus2.out_ready = 1'b0;
    bus2.k_len = KW'(1); bus2.in_a = {L2{8'sd1}}; bus2.in_b = {L2{8'sd1}}; bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("w_ovf_cleared", wv_t'(acc_ovf2), wv_t'(1'b0));
    repeat (3) @(negedge clk);
    bus2.out_ready = 1'b1; @(negedge clk); bus2.out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
